uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Purpose: FIFO-buffered UART transmitter with build-time data bits, parity and stop bits.
// Latency: a word written into an empty FIFO while idle drives the start bit one cycle after the accepting edge.
// Backpressure: tx_ready drops when the FIFO is full or rst_n is low; a word is stored only when tx_valid and tx_ready are both high.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        idx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic                 push;
    logic                 pop;
    logic                 fifo_nempty;
    logic                 bit_last;
    logic                 frame_last;
    logic [DATA_BITS-1:0] head;

    assign head        = mem[rd_ptr];
    assign fifo_nempty = (fifo_level != '0);
    assign tx_ready    = rst_n && (fifo_level != LW'(FIFO_DEPTH));
    assign push        = tx_valid && tx_ready;
    assign bit_last    = (bit_cnt == CW'(CLKS_PER_BIT - 1));
    assign frame_last  = (state == STOP) && bit_last && (stop_cnt == 1'(STOP_BITS - 1));
    // The serializer takes the head word either from IDLE or at the very end of the last stop bit,
    // so back-to-back frames have no idle cycle between them.
    assign pop         = fifo_nempty && ((state == IDLE) || frame_last);

    // FIFO storage; contents need no reset because the pointers and level are flushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; push and pop on one edge cancel in the level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Frame serializer: a registered line level per state, with a per-bit cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= (PARITY == 1) ? ~^head : ^head;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end else begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                START: begin
                    bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
                    if (bit_last) begin
                        tx    <= shreg[0];
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
                    if (bit_last) begin
                        if (idx == IW'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= PAR;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            idx   <= idx + IW'(1);
                            tx    <= shreg[1];
                            shreg <= shreg >> 1;
                        end
                    end
                end
                PAR: begin
                    bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
                    if (bit_last) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
                    if (frame_last) begin
                        if (pop) begin
                            shreg   <= head;
                            par_bit <= (PARITY == 1) ? ~^head : ^head;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (bit_last) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Purpose: scoreboard bench for uart_tx_cfg across 8N1, 8E1, 8O1 and 8N2 instances (4 clocks per bit, FIFO depth 4).
// Latency: expected frames are queued when a write is seen and matched cycle by cycle against the serial line.
// Backpressure: producers honour each instance's tx_ready; fifo_level and tx_ready are checked against the queue occupancy.
module tb_uart_tx_cfg;

    localparam int CPB = 4;
    localparam int ND  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] vld;
    logic [7:0] dat [ND];
    wire  [3:0] rdy;
    wire  [3:0] txl;
    wire  [3:0] bsy;
    wire  [2:0] lvl [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        uart_tx_cfg #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (8),
            .PARITY       ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
            .STOP_BITS    ((g == 3) ? 2 : 1),
            .FIFO_DEPTH   (4)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .tx_data    (dat[g]),
            .tx_valid   (vld[g]),
            .tx_ready   (rdy[g]),
            .tx         (txl[g]),
            .busy       (bsy[g]),
            .fifo_level (lvl[g])
        );
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // scoreboard: words accepted by each instance, and the cycle they were seen
    logic [7:0]  wq   [ND][256];
    int          wcyc [ND][256];
    int          wi   [ND];
    int          ri   [ND];
    // producer source lists
    logic [7:0]  sw   [ND][256];
    int          s_wi [ND];
    int          s_ri [ND];
    logic        hold [ND];
    // frame currently being observed on each line
    int          fpos [ND];
    int          flen [ND];
    logic [15:0] fbits[ND];
    logic        prev_rst_low;

    function automatic int par_of(input int g);
        return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    endfunction

    function automatic int stop_of(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, stop ones.
    function automatic void build_frame(input int g, input logic [7:0] w,
                                        output logic [15:0] bits, output int nbits);
        int ones;
        ones  = $countones(w);
        bits  = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = w[i];
        nbits = 9;
        if (par_of(g) != 0) begin
            // even: parity bit makes total ones even; odd: makes it odd
            bits[nbits] = (par_of(g) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            nbits++;
        end
        nbits += stop_of(g);
    endfunction

    task automatic chk(input string name, input int g, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0h want %0h", name, g, cyc, act, exp);
        end
    endtask

    task automatic add_word(input int g, input logic [7:0] w);
        sw[g][s_wi[g]] = w;
        s_wi[g]++;
    endtask

    task automatic clear_src();
        for (int g = 0; g < ND; g++) begin
            s_ri[g] = s_wi[g];
            vld[g]  = 1'b0;
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int k = 0; k < max_cycles && !done; k++) begin
            @(posedge clk);
            #2;
            done = 1'b1;
            for (int g = 0; g < ND; g++) begin
                if (s_ri[g] != s_wi[g] || ri[g] != wi[g] || fpos[g] != -1 || bsy[g] !== 1'b0) done = 1'b0;
            end
        end
        chk("drain", 0, 16'(done), 16'(1));
    endtask

    initial begin
        rst_n        = 1'b0;
        vld          = '0;
        prev_rst_low = 1'b1;
        for (int g = 0; g < ND; g++) begin
            dat[g]  = 8'h00;
            wi[g]   = 0;
            ri[g]   = 0;
            s_wi[g] = 0;
            s_ri[g] = 0;
            fpos[g] = -1;
            flen[g] = 0;
            fbits[g] = '1;
            hold[g] = 1'b1;
        end
        fork
            // monitor + producer: checks at negedge, drives just after posedge
            begin
                forever begin
                    @(negedge clk);
                    for (int g = 0; g < ND; g++) begin
                        int nb;
                        if (prev_rst_low) begin
                            chk("rst_tx", g, 16'(txl[g]), 16'(1));
                            chk("rst_busy", g, 16'(bsy[g]), 16'(0));
                            chk("rst_level", g, 16'(lvl[g]), 16'(0));
                            chk("rst_ready", g, 16'(rdy[g]), 16'(rst_n));
                        end else begin
                            if (fpos[g] >= 0) begin
                                chk("line", g, 16'(txl[g]), 16'(fbits[g][fpos[g] / CPB]));
                                chk("busy_frame", g, 16'(bsy[g]), 16'(1));
                                fpos[g]++;
                                if (fpos[g] == flen[g]) fpos[g] = -1;
                            end else if (txl[g] === 1'b0) begin
                                if (ri[g] < wi[g]) begin
                                    chk("early_start", g, 16'(wcyc[g][ri[g]] <= cyc - 2), 16'(1));
                                    build_frame(g, wq[g][ri[g]], fbits[g], nb);
                                    flen[g] = nb * CPB;
                                    ri[g]++;
                                    chk("busy_start", g, 16'(bsy[g]), 16'(1));
                                    fpos[g] = 1;
                                end else begin
                                    total++;
                                    bad++;
                                    $display("FAIL unexpected_start dut%0d cycle %0d: got tx 0 want 1", g, cyc);
                                end
                            end else begin
                                chk("busy_idle", g, 16'(bsy[g]), 16'(0));
                                if (ri[g] < wi[g])
                                    chk("start_latency", g, 16'(wcyc[g][ri[g]] >= cyc - 1), 16'(1));
                            end
                            chk("level", g, 16'(lvl[g]), 16'(wi[g] - ri[g]));
                            chk("ready", g, 16'(rdy[g]), 16'(rst_n && (wi[g] - ri[g] != 4)));
                        end
                        if (!rst_n) begin
                            ri[g]   = wi[g];
                            fpos[g] = -1;
                        end else if (vld[g] && rdy[g]) begin
                            wq[g][wi[g]]   = dat[g];
                            wcyc[g][wi[g]] = cyc;
                            wi[g]++;
                            s_ri[g]++;
                        end
                    end
                    prev_rst_low = !rst_n;
                    cyc++;
                    @(posedge clk);
                    #1;
                    for (int g = 0; g < ND; g++) begin
                        if (s_ri[g] < s_wi[g] && (hold[g] || $urandom_range(0, 2) != 0)) begin
                            vld[g] = 1'b1;
                            dat[g] = sw[g][s_ri[g]];
                        end else begin
                            vld[g] = 1'b0;
                            dat[g] = 8'($urandom);
                        end
                    end
                end
            end
            // test sequence
            begin
                // reset held 3 cycles with writes presented; nothing may be stored
                for (int g = 0; g < ND; g++) add_word(g, 8'h3C);
                repeat (3) @(posedge clk);
                #2;
                rst_n = 1'b1;
                clear_src();
                repeat (20) @(posedge clk);

                // single frames: 8N1 0xA5, 8E1 0x07, 8O1 0x07, 8N2 0x00
                add_word(0, 8'hA5);
                add_word(1, 8'h07);
                add_word(2, 8'h07);
                add_word(3, 8'h00);
                wait_drain(400);

                // depth-4 fill with valid held high for six words
                #2;
                for (int i = 0; i < 6; i++) add_word(0, 8'($urandom));
                repeat (8) @(posedge clk);
                #2;
                chk("full_level", 0, 16'(lvl[0]), 16'(4));
                chk("full_ready", 0, 16'(rdy[0]), 16'(0));
                wait_drain(600);

                // two queued words per instance: back-to-back frames
                for (int g = 0; g < ND; g++) begin
                    add_word(g, 8'($urandom));
                    add_word(g, 8'($urandom));
                end
                wait_drain(400);

                // reset pulse during data bit 3 of a frame with words still queued
                for (int g = 0; g < ND; g++) begin
                    add_word(g, 8'($urandom));
                    add_word(g, 8'($urandom));
                end
                begin
                    int k;
                    for (k = 0; k < 200 && fpos[0] < 17; k++) @(posedge clk);
                    chk("reach_bit3", 0, 16'(fpos[0] >= 17), 16'(1));
                end
                #2;
                rst_n = 1'b0;
                clear_src();
                @(posedge clk);
                #2;
                rst_n = 1'b1;
                repeat (100) @(posedge clk);
                #2;
                for (int g = 0; g < ND; g++) chk("no_resume", g, 16'(wi[g] - ri[g]), 16'(0));

                // randomized traffic with random valid gaps
                for (int g = 0; g < ND; g++) begin
                    hold[g] = 1'b0;
                    for (int i = 0; i < 20; i++) add_word(g, 8'($urandom));
                end
                wait_drain(3000);

                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end

endmodule
